// File: rtl/crack_pkg.sv
// Shared types and helpers for the ARC4 key-search scheduler.
package crack_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int KEY_W_DEF = 24;
    localparam int MAX_LANES = 16;
    localparam int MAX_KEY_W = 32;

    typedef struct packed {
        logic                 any;
        logic [MAX_KEY_W-1:0] key;
    } min_key_t;

    // Smallest key among the flagged lanes; callers zero-extend into the max-sized vectors.
    function automatic min_key_t min_key(input logic [MAX_LANES-1:0]                vld,
                                         input logic [MAX_LANES-1:0][MAX_KEY_W-1:0] keys);
        min_key_t r;
        r.any = 1'b0;
        r.key = '1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (vld[i] && (!r.any || keys[i] < r.key)) begin
                r.any = 1'b1;
                r.key = keys[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crack_lane_pick.sv
// Priority encoder: lowest-index idle lane plus an any-idle flag.
module crack_lane_pick #(
    parameter int N_LANES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_LANES-1:0] idle,
    output logic [IDX_W-1:0]   idx,
    output logic               any_idle
);

    always_comb begin
        idx = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (idle[i]) idx = IDX_W'(i);
        end
    end

    assign any_idle = |idle;

endmodule

// File: rtl/crack_sched.sv
// Key-search scheduler: issues keys 0..limit across the lane array and
// reports the lowest matching key, or exhaustion.
module crack_sched
    import crack_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CNT_W   = KEY_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [KEY_W-1:0]         key_limit,
    output logic                     rdy,
    output logic [KEY_W-1:0]         key,
    output logic                     key_valid,
    output logic [CNT_W-1:0]         keys_tried,
    output logic [N_LANES-1:0]       lane_start,
    output logic [N_LANES*KEY_W-1:0] lane_key,
    output logic [N_LANES-1:0]       lane_abort,
    input  logic [N_LANES-1:0]       lane_done,
    input  logic [N_LANES-1:0]       lane_hit
);

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    state_t                        state_q, state_n;
    logic [KEY_W-1:0]              limit_q, best_q, key_q, best_n, hit_key;
    logic [CNT_W-1:0]              next_key_q;
    logic [N_LANES-1:0]            active_q, active_n, done_v, hit_v, start_oh;
    logic [N_LANES-1:0][KEY_W-1:0] lk_q;
    logic                          found_q, found_n, key_valid_q, abort_now_q;
    logic                          any_idle, issue, exhausted, accept, better;
    logic [IDX_W-1:0]              pick_idx;
    logic [MAX_LANES-1:0]                hv;
    logic [MAX_LANES-1:0][MAX_KEY_W-1:0] hk;
    min_key_t                      mk;
    logic                          unused_mk;

    crack_lane_pick #(.N_LANES(N_LANES), .IDX_W(IDX_W)) u_pick (
        .idle     (~active_q),
        .idx      (pick_idx),
        .any_idle (any_idle)
    );

    // Only lanes we actually launched may complete or hit.
    assign done_v = lane_done & active_q;
    assign hit_v  = done_v & lane_hit;

    always_comb begin
        hv = '0;
        hk = '0;
        hv[N_LANES-1:0] = hit_v;
        for (int i = 0; i < N_LANES; i++) hk[i][KEY_W-1:0] = lk_q[i];
    end

    assign mk        = min_key(hv, hk);
    assign hit_key   = mk.key[KEY_W-1:0];
    assign unused_mk = ^mk.key;

    assign exhausted = next_key_q > CNT_W'(limit_q);
    assign issue     = (state_q == RUN) && any_idle && !exhausted && !mk.any;
    assign accept    = en && rdy;
    assign better    = mk.any && (!found_q || hit_key < best_q);
    assign best_n    = better ? hit_key : best_q;
    assign found_n   = found_q | mk.any;
    assign active_n  = (active_q & ~done_v) | start_oh;

    // Start pulse carries next_key directly so the lane sees it on the launching edge.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign start_oh[g]                 = issue && (pick_idx == IDX_W'(g));
        assign lane_key[g*KEY_W +: KEY_W]  = start_oh[g] ? next_key_q[KEY_W-1:0] : lk_q[g];
        assign lane_abort[g]               = abort_now_q && active_q[g] && (lk_q[g] > best_q);
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE, DONE: if (en) state_n = RUN;
            RUN: begin
                if (mk.any)                          state_n = (active_n == '0) ? DONE : DRAIN;
                else if (exhausted && active_n == '0) state_n = DONE;
            end
            DRAIN:      if (active_n == '0) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            next_key_q  <= '0;
            active_q    <= '0;
            lk_q        <= '0;
            best_q      <= '0;
            found_q     <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            abort_now_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            active_q    <= active_n;
            abort_now_q <= (state_q == RUN) && (state_n == DRAIN);
            for (int i = 0; i < N_LANES; i++) begin
                if (start_oh[i]) lk_q[i] <= next_key_q[KEY_W-1:0];
            end
            if (issue) next_key_q <= next_key_q + CNT_W'(1);
            if (accept) begin
                limit_q     <= key_limit;
                next_key_q  <= '0;
                best_q      <= '0;
                found_q     <= 1'b0;
                key_valid_q <= 1'b0;
            end else begin
                best_q  <= best_n;
                found_q <= found_n;
                if (state_n == DONE && state_q != DONE) begin
                    key_valid_q <= found_n;
                    if (found_n) key_q <= best_n;
                end
            end
        end
    end

    // The issue counter doubles as the tried count: one increment per lane_start.
    assign rdy        = (state_q == IDLE) || (state_q == DONE);
    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign keys_tried = next_key_q;
    assign lane_start = start_oh;

endmodule

// File: doc/crack_sched.md
Name: crack_sched

Overview:
- Parametrised key-search scheduler that drives N_LANES independent ARC4 crack lanes (each: key in, decrypt, printable check).
- Hands out candidate keys in increasing order from 0 up to a programmable limit and collects lane results.
- Reports the lowest matching key, or exhaustion, to the top-level controller.
- Sits between the top-level en/rdy handshake and the lane array; holds no memories.

Parameters:
N_LANES, 4, number of crack lanes (1..16)
KEY_W, 24, key width in bits
CNT_W, KEY_W+1, width of the next-key and keys-tried counters (extra bit avoids wrap at all-ones)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  start request; sampled only while rdy=1
key_limit  in  KEY_W  highest key to try, inclusive; captured on accepted en
rdy  out  1  high in IDLE and DONE
key  out  KEY_W  lowest matching key; valid when key_valid=1
key_valid  out  1  search found a key; held until the next accepted en
keys_tried  out  CNT_W  number of lane_start pulses issued this search
lane_start  out  N_LANES  one-cycle pulse per lane; launches a decrypt
lane_key  out  N_LANES*KEY_W  per-lane key; lane i uses bits [i*KEY_W +: KEY_W]; stable from start until done
lane_abort  out  N_LANES  one-cycle pulse; lane must finish early
lane_done  in  N_LANES  one-cycle pulse; lane finished or aborted
lane_hit  in  N_LANES  qualified by lane_done; key decrypted to valid plaintext

Behaviour:
- Reset: state=IDLE, rdy=1, key=0, key_valid=0, keys_tried=0, lane_start=0, lane_abort=0, lane_key=0, active mask=0, next_key=0.
- Accept condition: en && rdy. On accept:
  - capture key_limit; clear key_valid, keys_tried and next_key
  - go to RUN; rdy falls the next cycle.
- RUN:
  - Each cycle, if any lane is idle and next_key <= limit, pulse lane_start on the lowest-index idle lane with lane_key=next_key.
  - That issue increments next_key and keys_tried and sets the lane's active bit.
  - At most one issue per cycle.
- Done handling (any state): a lane_done clears that lane's active bit. lane_done on an inactive lane is ignored.
- Hit:
  - Among lanes with lane_done & lane_hit in one cycle, select the smallest lane_key; record it as best and set found.
  - A later hit replaces best only if its key is smaller.
  - On the first hit in RUN, go to DRAIN and stop issuing.
  - In the cycle after entering DRAIN, pulse lane_abort on every active lane whose key > best. Lanes with smaller keys keep running.
- RUN to DONE: when next_key > limit and no lane is active and nothing was found, go to DONE with key_valid=0.
- DRAIN to DONE: once no lane is active, go to DONE with key=best, key_valid=1.
- A lane_done arriving in the same cycle as its abort pulse is legal; that lane is not re-aborted.
- DONE: rdy=1; outputs held. en starts a new search directly (DONE to RUN).
- key_limit=0: exactly one key (0) is issued.
- key_limit=all-ones: the CNT_W counter ends at 2^KEY_W with no wrap.
- en while rdy=0 is ignored.
- Mid-search reset: all outputs return to reset values immediately (asynchronous). Lanes are reset by the same rst.
- Latency:
  - accept to first lane_start: 1 cycle
  - final lane_done to rdy=1: 1 cycle

Decomposition:
- Package crack_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - default KEY_W
  - a min-key-select function (combinational reduction over N_LANES)
- One sub-module: crack_lane_pick, a priority encoder returning the lowest idle lane index plus an any_idle flag.

Test Plan:
- N_LANES=4, lane model latency 20 cycles, key_limit=0x00001F, only key 0x000018 hits. Expected response:
  - done with key=0x000018, key_valid=1
  - all lanes with keys > 0x18 aborted
  - keys_tried ≥ 25
- key_limit=0x00000F, no hits. Expected response:
  - DONE with key_valid=0
  - keys_tried=16
  - each key 0x0 to 0xF issued exactly once, in order
- Keys 0x05 and 0x09 hit, lane latency varied so 0x09 finishes first. Expected response:
  - 0x05's lane is not aborted
  - final key=0x05
- Two lanes assert lane_done & lane_hit in the same cycle with keys 0x0C and 0x0A -> key=0x0A.
- key_limit=0 -> exactly one lane_start with key 0; keys_tried=1; rdy rises 1 cycle after that lane_done.
- Assert rst mid-RUN with 3 lanes active. Expected response:
  - all outputs at reset values in the same cycle
  - a new en then restarts the search from key 0
- en pulsed while rdy=0 -> no effect.
